// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared widths and enums for the two-port RAM arbiter
package ram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

endpackage

// File: rtl/ram_arbiter_2port_rr.sv
// rtl/ram_arbiter_2port_rr.sv - two-way round-robin grant with registered priority pointer
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output grant_e     grant_o
);

  port_e prio_q, prio_d;

  // Grant is suppressed while reset is high so nothing reaches the RAM.
  always_comb begin
    grant_o = GNT_NONE;
    if (!reset) begin
      case (req_i)
        2'b01:   grant_o = GNT_A;
        2'b10:   grant_o = GNT_B;
        2'b11:   grant_o = (prio_q == PORT_A) ? GNT_A : GNT_B;
        default: grant_o = GNT_NONE;
      endcase
    end
  end

  always_comb begin
    prio_d = prio_q;
    case (grant_o)
      GNT_A:   prio_d = PORT_B;
      GNT_B:   prio_d = PORT_A;
      default: prio_d = prio_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= PORT_A;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/ram_arbiter_2port.sv
// rtl/ram_arbiter_2port.sv - shares one zero-delay-read RAM between ports A and B
module ram_arbiter_2port
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_writedata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_readdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_writedata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_readdata,
  output logic                  b_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_writedata,
  input  logic [DATA_WIDTH-1:0] ram_readdata
);

  grant_e grant;

  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_readdata_q, b_readdata_q;

  rr_arbiter_2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req_i   ({b_req, a_req}),
    .grant_o (grant)
  );

  always_comb begin
    ram_address   = '0;
    ram_writedata = '0;
    ram_write     = 1'b0;
    ram_read      = 1'b0;
    case (grant)
      GNT_A: begin
        ram_address   = a_address;
        ram_writedata = a_writedata;
        ram_write     = a_write;
        ram_read      = !a_write;
      end
      GNT_B: begin
        ram_address   = b_address;
        ram_writedata = b_writedata;
        ram_write     = b_write;
        ram_read      = !b_write;
      end
      default: ;
    endcase
  end

  assign a_ack = (grant == GNT_A);
  assign b_ack = (grant == GNT_B);

  assign a_rvalid_d = a_ack && !a_write;
  assign b_rvalid_d = b_ack && !b_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_readdata_q <= '0;
      b_readdata_q <= '0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      if (a_rvalid_d) a_readdata_q <= ram_readdata;
      if (b_rvalid_d) b_readdata_q <= ram_readdata;
    end
  end

  // A read captured just before reset rises must not be reported.
  assign a_rvalid   = a_rvalid_q && !reset;
  assign b_rvalid   = b_rvalid_q && !reset;
  assign a_readdata = a_readdata_q;
  assign b_readdata = b_readdata_q;

endmodule

// File: doc/ram_arbiter_2port.md
# ram_arbiter_2port

Two-requester arbiter that shares the single-port, zero-delay-read 16x4096 RAM between port A (MU0 CPU) and port B (debug/loader DMA). Each requester uses a req/ack handshake; the arbiter drives the RAM's address/read/write/writedata pins and returns registered read data with a valid strobe. Round-robin priority prevents either port starving the other. The arbiter sits between the requesters and the RAM instance.

## Interface
Parameters:
- ADDR_WIDTH, 12, RAM word-address width
- DATA_WIDTH, 16, RAM data width

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  port A request; held until a_ack
- a_write  in  1  port A: 1 = write, 0 = read
- a_address  in  ADDR_WIDTH  port A word address
- a_writedata  in  DATA_WIDTH  port A write data
- a_ack  out  1  port A request accepted this cycle
- a_readdata  out  DATA_WIDTH  port A read data, valid when a_rvalid
- a_rvalid  out  1  port A read data strobe, one cycle
- b_req, b_write, b_address, b_writedata, b_ack, b_readdata, b_rvalid  same as port A, for port B
- ram_address  out  ADDR_WIDTH  to RAM address
- ram_read  out  1  to RAM read
- ram_write  out  1  to RAM write
- ram_writedata  out  DATA_WIDTH  to RAM writedata
- ram_readdata  in  DATA_WIDTH  from RAM readdata (combinational)

## Operation
- State: priority pointer `prio` (A or B), registered read-return flags and data per port.
- Grant, combinational each cycle: only one req → that port; both req → port equal to `prio`; none → idle.
- Granted port: its ack = 1; ram_address/ram_writedata = its address/data; ram_write = its write; ram_read = !its write. Non-granted ack = 0.
- Idle: ram_read = 0, ram_write = 0, ram_address = 0, ram_writedata = 0.
- Pointer update at posedge: after grant to A, prio ← B; after grant to B, prio ← A; idle cycle leaves prio unchanged.
- Read grant to port X at cycle n: ram_readdata registered into x_readdata at end of n; x_rvalid = 1 in cycle n+1 only.
- Write grant: RAM commits at end of cycle n; no rvalid.
- Requester must hold req and payload stable until ack; deasserting req before ack withdraws request (legal, no side effect).
- x_readdata holds last captured value until next read for that port.
- Read-after-write, same address, different ports, consecutive cycles: read returns new data (RAM write commits before next-cycle read).

## Timing
- Reset values: prio = A; a_rvalid = b_rvalid = 0; a_readdata = b_readdata = 0; all ack/ram_* outputs 0 while reset is high (grant suppressed).
- Reset asserted the cycle after a read grant: rvalid stays 0, data discarded.
- Ack latency: 0 cycles when granted (same cycle as req). Read data latency: 1 cycle after ack.
- Worst-case wait under contention: 1 cycle (other port served once, then this port).
- Throughput: one RAM access per cycle; back-to-back grants to the same port permitted when the other port is idle.
- ack, ram_* are combinational from req/prio; no combinational path from ram_readdata to any output.

## Structure
- Package ram_arb_pkg: ADDR_WIDTH/DATA_WIDTH defaults, port-id enum (PORT_A, PORT_B), grant enum (GNT_NONE, GNT_A, GNT_B).
- Sub-module rr_arbiter_2: inputs clk, reset, req[1:0]; outputs grant enum; owns prio register. Top module holds the muxes and read-return registers.

## Test plan
- Reset: hold reset 2 cycles with a_req=b_req=1 → all acks, ram_read, ram_write, rvalids 0; after release, first contested grant goes to A.
- Single-port write/read: A writes 0x0123 → 0xBEEF, then reads 0x0123 → a_ack each cycle, a_rvalid next cycle with a_readdata=0xBEEF, b_rvalid stays 0.
- Contention: A and B both request reads continuously from cycle 0 → grants alternate A,B,A,B; each rvalid exactly one cycle after its ack.
- Cross-port RAW: cycle n B writes 0x0FFF=0x5A5A, cycle n+1 A reads 0x0FFF → a_readdata=0x5A5A at n+2.
- Idle pointer hold: grant to B, then 3 idle cycles, then both request → A granted first.
- Reset mid-read: A read acked at cycle n, reset at n+1 → a_rvalid remains 0; prio back to A.
